// File: rtl/sram_like_responder_if.sv
// sram_like_responder_if
// Purpose : bundles the sram-like request/response bus between an initiator
//           (CPU inst/data port or bench) and the memory responder.
// Signals : req/wr/size/wstrb/addr/wdata  initiator -> responder
//           addr_ok/data_ok/rdata         responder -> initiator
// Modports: master (initiator side), slave (responder side).
interface sram_like_responder_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_responder.sv
// sram_like_responder
// Purpose : slave end of the sram-like bus. Accepts req/addr_ok handshakes,
//           performs word reads and byte-strobed writes on an internal RAM and
//           returns in-order data_ok responses a fixed LAT cycles after
//           acceptance. Up to DEPTH requests may be outstanding.
// Ports   : clk     - clock, all state on rising edge
//           resetn  - asynchronous active-low reset
//           stall   - forces addr_ok low (backpressure injection)
//           bus     - sram-like slave modport (req/wr/size/wstrb/addr/wdata in,
//                     addr_ok/data_ok/rdata out)
module sram_like_responder #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4,
    parameter int LAT    = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 stall,
    sram_like_responder_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(LAT - 1);

    // Word storage; intentionally not reset so contents survive resetn pulses.
    logic [31:0]       ram [0:(1 << ADDR_W) - 1];

    logic [31:0]       ent_data_q  [DEPTH];
    logic [31:0]       ent_data_d  [DEPTH];
    logic [TMR_W-1:0]  ent_timer_q [DEPTH];
    logic [TMR_W-1:0]  ent_timer_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [ADDR_W-1:0] word_idx;
    logic              addr_ok;
    logic              data_ok;
    logic [31:0]       rdata;
    logic              unused_bits;

    assign word_idx    = bus.addr[ADDR_W+1:2];
    // size and the aliasing/byte-offset address bits carry no meaning here.
    assign unused_bits = ^{bus.size, bus.addr[31:ADDR_W+2], bus.addr[1:0]};

    // Handshake and response. Full is judged on the registered count, so a
    // pop in the same cycle only frees its slot on the following cycle.
    // rdata is forced to 0 whenever no response is presented.
    always_comb begin
        addr_ok = resetn & bus.req & ~stall & (count_q != FULL_CNT);
        data_ok = (count_q != '0) && (ent_timer_q[rd_ptr_q] == '0);
        rdata   = data_ok ? ent_data_q[rd_ptr_q] : 32'h0;
    end

    assign bus.addr_ok = addr_ok;
    assign bus.data_ok = data_ok;
    assign bus.rdata   = rdata;

    // Queue next state. Every timer counts down independently of queue
    // position; stale slots simply sit at 0 and get reloaded on push.
    // A read captures the RAM word at acceptance, so any older write (which
    // commits at its own acceptance) is already visible: program order holds.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_data_d[i]  = ent_data_q[i];
            ent_timer_d[i] = (ent_timer_q[i] == '0) ? '0 : ent_timer_q[i] - TMR_W'(1);
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (addr_ok) begin
            ent_timer_d[wr_ptr_q] = TMR_INIT;
            ent_data_d[wr_ptr_q]  = bus.wr ? 32'h0 : ram[word_idx];
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end

        if (data_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({addr_ok, data_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue state registers; reset drops every pending response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_data_q[i]  <= '0;
                ent_timer_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_data_q[i]  <= ent_data_d[i];
                ent_timer_q[i] <= ent_timer_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Byte-strobed write commit at the acceptance edge.
    always_ff @(posedge clk) begin
        if (addr_ok && bus.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wstrb[b]) begin
                    ram[word_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_like_responder.sv
// tb_sram_like_responder
// Purpose : directed self-checking bench for sram_like_responder.
//           dut_a uses LAT=2/DEPTH=4, dut_b uses LAT=6/DEPTH=4 so that the
//           queue can fill up. Inputs change #1 after the rising edge and
//           outputs are sampled on the falling edge.
module tb_sram_like_responder;

    logic clk;
    logic resetn;
    logic stall_a;
    logic stall_b;

    int checks;
    int fails;

    sram_like_responder_if bus_a ();
    sram_like_responder_if bus_b ();

    sram_like_responder #(.ADDR_W(10), .DEPTH(4), .LAT(2)) dut_a (
        .clk    (clk),
        .resetn (resetn),
        .stall  (stall_a),
        .bus    (bus_a)
    );

    sram_like_responder #(.ADDR_W(10), .DEPTH(4), .LAT(6)) dut_b (
        .clk    (clk),
        .resetn (resetn),
        .stall  (stall_b),
        .bus    (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus cycle on dut_a: drive after the edge, return at the falling edge.
    task automatic drive_a(input logic rq, input logic w, input logic [3:0] st,
                           input logic [31:0] ad, input logic [31:0] wd, input logic stl);
        @(posedge clk);
        #1;
        bus_a.req   = rq;
        bus_a.wr    = w;
        bus_a.size  = 2'd2;
        bus_a.wstrb = st;
        bus_a.addr  = ad;
        bus_a.wdata = wd;
        stall_a     = stl;
        @(negedge clk);
    endtask

    task automatic drive_b(input logic rq, input logic w, input logic [3:0] st,
                           input logic [31:0] ad, input logic [31:0] wd);
        @(posedge clk);
        #1;
        bus_b.req   = rq;
        bus_b.wr    = w;
        bus_b.size  = 2'd2;
        bus_b.wstrb = st;
        bus_b.addr  = ad;
        bus_b.wdata = wd;
        stall_b     = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        resetn = 1'b0;
        bus_a.req = 1'b1;
        bus_b.req = 1'b1;
        #3;
        checks++;
        if (bus_a.addr_ok !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_addr_ok_a: got %b expected 0", bus_a.addr_ok);
        end
        checks++;
        if (bus_a.data_ok !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_data_ok_a: got %b expected 0", bus_a.data_ok);
        end
        checks++;
        if (bus_a.rdata !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset_rdata_a: got %h expected 0", bus_a.rdata);
        end
        checks++;
        if (bus_b.addr_ok !== 1'b0 || bus_b.data_ok !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_b: got addr_ok %b data_ok %b expected 0 0",
                     bus_b.addr_ok, bus_b.data_ok);
        end
        repeat (2) @(posedge clk);
        #1;
        bus_a.req = 1'b0;
        bus_b.req = 1'b0;
        resetn    = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_a.data_ok !== 1'b0 || bus_a.rdata !== 32'h0) begin
            fails++;
            $display("[TB] FAIL post_reset_idle: got data_ok %b rdata %h expected 0 0",
                     bus_a.data_ok, bus_a.rdata);
        end
    endtask

    // Write then read of the same word; each response exactly LAT after accept.
    task automatic test_write_read();
        logic        exp_dok [5];
        logic [31:0] exp_rd  [5];
        $display("[TB] test_write_read");
        exp_dok = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        exp_rd  = '{32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
        for (int c = 0; c < 5; c++) begin
            case (c)
                0:       drive_a(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0);
                1:       drive_a(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
                default: drive_a(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
            endcase
            if (c < 2) begin
                checks++;
                if (bus_a.addr_ok !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL wr_rd_addr_ok c%0d: got %b expected 1", c, bus_a.addr_ok);
                end
            end
            checks++;
            if (bus_a.data_ok !== exp_dok[c] || bus_a.rdata !== exp_rd[c]) begin
                fails++;
                $display("[TB] FAIL wr_rd_resp c%0d: got data_ok %b rdata %h expected %b %h",
                         c, bus_a.data_ok, bus_a.rdata, exp_dok[c], exp_rd[c]);
            end
        end
    endtask

    // Partial strobe merges one byte; a zero strobe changes nothing but is answered.
    task automatic test_byte_strobe();
        $display("[TB] test_byte_strobe");
        for (int c = 0; c < 8; c++) begin
            case (c)
                0:       drive_a(1'b1, 1'b1, 4'hF, 32'h10, 32'h11223344, 1'b0);
                1:       drive_a(1'b1, 1'b1, 4'h2, 32'h10, 32'h0000AA00, 1'b0);
                2:       drive_a(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
                3:       drive_a(1'b1, 1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, 1'b0);
                4:       drive_a(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
                default: drive_a(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
            endcase
            if (c == 4 || c == 6) begin
                checks++;
                if (bus_a.data_ok !== 1'b1 || bus_a.rdata !== 32'h1122AA44) begin
                    fails++;
                    $display("[TB] FAIL strobe_read c%0d: got data_ok %b rdata %h expected 1 1122aa44",
                             c, bus_a.data_ok, bus_a.rdata);
                end
            end
            if (c == 5) begin
                checks++;
                if (bus_a.data_ok !== 1'b1 || bus_a.rdata !== 32'h0) begin
                    fails++;
                    $display("[TB] FAIL strobe_zero_wr_resp: got data_ok %b rdata %h expected 1 0",
                             bus_a.data_ok, bus_a.rdata);
                end
            end
            if (c == 7) begin
                checks++;
                if (bus_a.data_ok !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL strobe_drain: got data_ok %b expected 0", bus_a.data_ok);
                end
            end
        end
    endtask

    // 8 writes then 8 reads back to back; responses in consecutive cycles.
    task automatic test_back_to_back();
        logic        exp_aok;
        logic        exp_dok;
        logic [31:0] exp_rd;
        $display("[TB] test_back_to_back");
        for (int k = 0; k < 20; k++) begin
            if (k < 8)
                drive_a(1'b1, 1'b1, 4'hF, 32'h100 + 32'(4*k), 32'hC0DE0000 + 32'(k), 1'b0);
            else if (k < 16)
                drive_a(1'b1, 1'b0, 4'h0, 32'h100 + 32'(4*(k-8)), 32'h0, 1'b0);
            else
                drive_a(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
            exp_aok = (k < 16);
            exp_dok = (k >= 2) && (k < 18);
            exp_rd  = (k >= 10 && k < 18) ? 32'hC0DE0000 + 32'(k - 10) : 32'h0;
            checks++;
            if (bus_a.addr_ok !== exp_aok || bus_a.data_ok !== exp_dok || bus_a.rdata !== exp_rd) begin
                fails++;
                $display("[TB] FAIL b2b k%0d: got addr_ok %b data_ok %b rdata %h expected %b %b %h",
                         k, bus_a.addr_ok, bus_a.data_ok, bus_a.rdata, exp_aok, exp_dok, exp_rd);
            end
        end
    endtask

    // stall holds addr_ok low; the held request is taken on the first free cycle.
    task automatic test_stall();
        logic exp_aok;
        logic exp_dok;
        $display("[TB] test_stall");
        for (int c = 0; c < 7; c++) begin
            if (c < 4)
                drive_a(1'b1, 1'b0, 4'h0, 32'h104, 32'h0, (c < 3));
            else
                drive_a(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
            exp_aok = (c == 3);
            exp_dok = (c == 5);
            checks++;
            if (bus_a.addr_ok !== exp_aok || bus_a.data_ok !== exp_dok) begin
                fails++;
                $display("[TB] FAIL stall c%0d: got addr_ok %b data_ok %b expected %b %b",
                         c, bus_a.addr_ok, bus_a.data_ok, exp_aok, exp_dok);
            end
            if (c == 5) begin
                checks++;
                if (bus_a.rdata !== 32'hC0DE0001) begin
                    fails++;
                    $display("[TB] FAIL stall_rdata: got %h expected c0de0001", bus_a.rdata);
                end
            end
        end
    endtask

    // LAT=6 with DEPTH=4: accepts at 0-3 and 7-10, responses at 6-9 and 13-16.
    task automatic test_backpressure();
        int          idx;
        int          resp;
        logic        exp_aok;
        logic        exp_dok;
        logic [31:0] exp_rd;
        $display("[TB] test_backpressure");
        idx  = 0;
        resp = 0;
        for (int c = 0; c < 20; c++) begin
            if (idx < 4)
                drive_b(1'b1, 1'b1, 4'hF, 32'h200 + 32'(4*idx), 32'hB0000000 + 32'(idx));
            else if (idx < 8)
                drive_b(1'b1, 1'b0, 4'h0, 32'h200 + 32'(4*(idx-4)), 32'h0);
            else
                drive_b(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            if (c <= 10) begin
                exp_aok = (c < 4) || (c >= 7);
                checks++;
                if (bus_b.addr_ok !== exp_aok) begin
                    fails++;
                    $display("[TB] FAIL bp_addr_ok c%0d: got %b expected %b", c, bus_b.addr_ok, exp_aok);
                end
            end
            exp_dok = (c >= 6 && c <= 9) || (c >= 13 && c <= 16);
            checks++;
            if (bus_b.data_ok !== exp_dok) begin
                fails++;
                $display("[TB] FAIL bp_data_ok c%0d: got %b expected %b", c, bus_b.data_ok, exp_dok);
            end
            if (bus_b.data_ok === 1'b1) begin
                exp_rd = (resp < 4) ? 32'h0 : 32'hB0000000 + 32'(resp - 4);
                checks++;
                if (bus_b.rdata !== exp_rd) begin
                    fails++;
                    $display("[TB] FAIL bp_rdata resp%0d: got %h expected %h", resp, bus_b.rdata, exp_rd);
                end
                resp++;
            end
            if (bus_b.addr_ok === 1'b1) idx++;
        end
        checks++;
        if (idx != 8 || resp != 8) begin
            fails++;
            $display("[TB] FAIL bp_totals: got accepted %0d responded %0d expected 8 8", idx, resp);
        end
    endtask

    // Reset with 3 outstanding on dut_b drops them; the accepted write survives.
    task automatic test_reset_mid();
        int stale;
        $display("[TB] test_reset_mid");
        drive_b(1'b1, 1'b1, 4'hF, 32'h40, 32'h12345678);
        drive_b(1'b1, 1'b0, 4'h0, 32'h200, 32'h0);
        drive_b(1'b1, 1'b0, 4'h0, 32'h204, 32'h0);
        drive_b(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checks++;
        if (bus_b.data_ok !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rm_pre_reset: got data_ok %b expected 0", bus_b.data_ok);
        end
        #1;
        bus_b.req = 1'b1;
        resetn    = 1'b0;
        #1;
        checks++;
        if (bus_b.data_ok !== 1'b0 || bus_b.addr_ok !== 1'b0 || bus_b.rdata !== 32'h0) begin
            fails++;
            $display("[TB] FAIL rm_in_reset: got data_ok %b addr_ok %b rdata %h expected 0 0 0",
                     bus_b.data_ok, bus_b.addr_ok, bus_b.rdata);
        end
        @(posedge clk);
        #1;
        bus_b.req = 1'b0;
        resetn    = 1'b1;
        stale     = 0;
        for (int c = 0; c < 10; c++) begin
            drive_b(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            if (bus_b.data_ok !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) begin
            fails++;
            $display("[TB] FAIL rm_stale: got %0d stale data_ok cycles expected 0", stale);
        end
        drive_b(1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
        checks++;
        if (bus_b.addr_ok !== 1'b1) begin
            fails++;
            $display("[TB] FAIL rm_readback_accept: got %b expected 1", bus_b.addr_ok);
        end
        for (int c = 1; c <= 6; c++) begin
            drive_b(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            checks++;
            if (bus_b.data_ok !== (c == 6)) begin
                fails++;
                $display("[TB] FAIL rm_readback_timing c%0d: got %b expected %b", c, bus_b.data_ok, (c == 6));
            end
        end
        checks++;
        if (bus_b.rdata !== 32'h12345678) begin
            fails++;
            $display("[TB] FAIL rm_readback_data: got %h expected 12345678", bus_b.rdata);
        end
    endtask

    // Hard stop in case anything stalls the sequence.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    // Test sequence.
    initial begin
        checks      = 0;
        fails       = 0;
        resetn      = 1'b0;
        stall_a     = 1'b0;
        stall_b     = 1'b0;
        bus_a.req   = 1'b0;
        bus_a.wr    = 1'b0;
        bus_a.size  = 2'd2;
        bus_a.wstrb = 4'h0;
        bus_a.addr  = 32'h0;
        bus_a.wdata = 32'h0;
        bus_b.req   = 1'b0;
        bus_b.wr    = 1'b0;
        bus_b.size  = 2'd2;
        bus_b.wstrb = 4'h0;
        bus_b.addr  = 32'h0;
        bus_b.wdata = 32'h0;

        test_reset();
        test_write_read();
        test_byte_strobe();
        test_back_to_back();
        test_stall();
        test_backpressure();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
